// File: rtl/aes_pkg.sv
// Shared types and defaults for the AES request scheduler and its bench.
package aes_pkg;

  typedef logic [127:0] aes_block_t;

  localparam int unsigned AES_LATENCY_DEFAULT = 11;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    HOLD
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr, wrapping.
// The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [IdxW-1:0] gnt_idx,
  output logic            any
);

  // Scan ptr+1 .. ptr+N (mod N) and take the first set request.
  always_comb begin
    logic [IdxW-1:0] cand_idx;
    cand_idx   = '0;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand_idx = IdxW'((32'(ptr) + i) % N);
      if (!any && req[cand_idx]) begin
        any                  = 1'b1;
        gnt_idx              = cand_idx;
        gnt_onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_req_scheduler.sv
// Shares one fixed-latency AES-128 core among NUM_REQ requesters: round-robin issue,
// latency wait, one-entry response register and sticky timeout/spurious-result flags.
module aes_req_scheduler
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned AES_LATENCY = AES_LATENCY_DEFAULT,
  parameter int unsigned TIMEOUT     = 16,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NUM_REQ-1:0]     req_valid_in,
  output logic [NUM_REQ-1:0]     req_ready_out,
  input  logic [NUM_REQ*128-1:0] req_data_in,
  input  logic [NUM_REQ*128-1:0] req_key_in,
  output logic                   rsp_valid_out,
  input  logic                   rsp_ready_in,
  output logic [127:0]           rsp_data_out,
  output logic [ID_W-1:0]        rsp_id_out,
  output logic                   aes_valid_out,
  output logic [127:0]           aes_data_out,
  output logic [127:0]           aes_key_out,
  input  logic [127:0]           aes_res_in,
  input  logic                   aes_res_valid_in,
  output logic                   busy_out,
  output logic                   err_timeout_out,
  output logic                   err_spurious_out
);

  // Counter must reach TIMEOUT-1 before saturating.
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  sched_state_t     r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_id;
  logic [CNT_W-1:0] r_cnt;
  aes_block_t       r_rsp_data;
  logic [ID_W-1:0]  r_rsp_id;
  logic             r_rsp_valid;
  logic             r_err_timeout;
  logic             r_err_spurious;

  logic [NUM_REQ-1:0] w_gnt_onehot;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_any;
  logic               w_issue;
  logic [CNT_W:0]     w_cnt_inc;
  aes_block_t         w_sel_data;
  aes_block_t         w_sel_key;

  rr_arbiter #(
    .N(NUM_REQ)
  ) u_arb (
    .req       (req_valid_in),
    .ptr       (r_rr_ptr),
    .gnt_onehot(w_gnt_onehot),
    .gnt_idx   (w_gnt_idx),
    .any       (w_any)
  );

  // Issue decision and the combinational core/requester handshake.
  always_comb begin
    w_issue       = w_any && ((r_state == IDLE) || ((r_state == HOLD) && rsp_ready_in));
    w_sel_data    = req_data_in[32'(w_gnt_idx) * 128 +: 128];
    w_sel_key     = req_key_in[32'(w_gnt_idx) * 128 +: 128];
    w_cnt_inc     = {1'b0, r_cnt} + (CNT_W + 1)'(1);
    aes_valid_out = w_issue;
    req_ready_out = w_issue ? w_gnt_onehot : '0;
    aes_data_out  = w_issue ? w_sel_data : '0;
    aes_key_out   = w_issue ? w_sel_key : '0;
  end

  // Scheduler FSM, latency counter, response register and sticky error flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_rr_ptr       <= ID_W'(NUM_REQ - 1);
      r_id           <= '0;
      r_cnt          <= '0;
      r_rsp_data     <= '0;
      r_rsp_id       <= '0;
      r_rsp_valid    <= 1'b0;
      r_err_timeout  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (aes_res_valid_in) r_err_spurious <= 1'b1;
          if (w_issue) r_state <= BUSY;
        end
        BUSY: begin
          if (aes_res_valid_in) begin
            r_rsp_data  <= aes_res_in;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
            r_state     <= HOLD;
            // Off-schedule result is still delivered, but flagged.
            if (w_cnt_inc != (CNT_W + 1)'(AES_LATENCY)) r_err_spurious <= 1'b1;
          end else if (w_cnt_inc == (CNT_W + 1)'(TIMEOUT)) begin
            // Job is dropped; no response is produced.
            r_err_timeout <= 1'b1;
            r_state       <= IDLE;
          end
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
        end
        HOLD: begin
          // A held response is never overwritten by a stray result.
          if (aes_res_valid_in) r_err_spurious <= 1'b1;
          if (rsp_ready_in) begin
            r_rsp_valid <= 1'b0;
            r_state     <= w_issue ? BUSY : IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Issue only happens from IDLE/HOLD, so this never races the BUSY counter update.
      if (w_issue) begin
        r_rr_ptr <= w_gnt_idx;
        r_id     <= w_gnt_idx;
        r_cnt    <= '0;
      end
    end
  end

  assign rsp_valid_out    = r_rsp_valid;
  assign rsp_data_out     = r_rsp_data;
  assign rsp_id_out       = r_rsp_id;
  assign busy_out         = (r_state != IDLE);
  assign err_timeout_out  = r_err_timeout;
  assign err_spurious_out = r_err_spurious;

endmodule
